alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Sequential front-end that issues operations to the 8-bit ALU and retires their results. Accepts one instruction at a time over a valid/ready handshake and drives the ALU operand, sub and op-select lines from registers. Waits a fixed settle time (longer for multiply/divide), then writes the result into the accumulator and a flag register. Sits between the instruction fetch/decode path and the combinational ALU, and owns the accumulator.

## Interface
- `DATA_W`, 8: datapath width; only 8 is supported.
- `MULDIV_WAIT`, 2: extra settle cycles for MUL/DIV, range 0..15.

- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `instr_valid`, in, 1: instruction offered.
- `instr_ready`, out, 1: sequencer can accept.
- `instr_opcode`, in, 3: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 DIV, 6 LDA, 7 CLRF.
- `instr_operand`, in, 8: B operand, or load value for LDA.
- `alu_a`, out, 8: to ALU a; always the accumulator.
- `alu_b`, out, 8: to ALU b; latched operand.
- `alu_sub`, out, 1: to ALU sub.
- `alu_op_select`, out, 3: to ALU op_select.
- `alu_result`, in, 8: ALU result.
- `alu_cout`, `alu_overflow`, `alu_no`, `alu_zo`, in, 1 each: ALU flags.
- `acc`, out, 8: accumulator.
- `flags`, out, 4: {C,V,N,Z}.
- `err_div0`, out, 1: sticky divide-by-zero error.
- `busy`, out, 1: not in IDLE.
- `done`, out, 1: one-cycle retire pulse.

## Operation
- The handshake completes on an edge where `instr_valid && instr_ready`. `instr_ready` = (state == IDLE). The producer holds valid and payload until accepted.
- At accept, latch the opcode and operand.
  - `alu_b` takes the operand.
  - `alu_op_select` takes the opcode for 0..5, otherwise 0.
  - `alu_sub` = (opcode == SUB).
  - ALU drive registers hold their values until the next accept.
- States:
  - IDLE → EXEC on accept.
  - EXEC counts `wait_cnt` down from 0 (ADD/SUB/AND/OR) or from MULDIV_WAIT (MUL/DIV). At count 0, capture the result and go to WB.
  - WB asserts `done` and returns to IDLE.
  - LDA and CLRF skip the ALU and go IDLE → WB directly, committing at the accept edge.
- Commit rules:
  - ADD/SUB: `acc`←`alu_result`; C,V,N,Z←`alu_cout`, `alu_overflow`, `alu_no`, `alu_zo`.
  - AND/OR/MUL/DIV: `acc`←`alu_result`; C=V=0; N=result[7]; Z=(result==0).
  - LDA: `acc`←operand; C,V unchanged; N and Z from the operand.
  - CLRF: flags←0 and `err_div0`←0; `acc` unchanged.
- `instr_valid` while busy is ignored; the sequencer never accepts a second instruction before WB completes.
- Async `rst` mid-operation: everything returns to reset values immediately, no `done` is emitted, and the in-flight instruction is dropped.

## Timing
- Reset values: `acc`, `flags`, `alu_a`, `alu_b`, `alu_op_select`, `alu_sub`, `err_div0`, `done`, `busy` all 0. `instr_ready` is 1 once out of reset.
- Accept at edge T0 puts EXEC in cycle T0+1.
- ADD/SUB/AND/OR: commit at edge T0+1; `done` high in cycle T0+2; `instr_ready` high in cycle T0+3.
- MUL/DIV: commit at edge T0+1+MULDIV_WAIT; `done` high in cycle T0+2+MULDIV_WAIT.
- LDA/CLRF: commit at edge T0; `done` high in cycle T0+1.
- `acc` and `flags` change only at the commit edge, and `done` follows one cycle later.
- `busy` is high from the cycle after accept through the `done` cycle.

## Configuration
- `ALU_SEQ_DIV0_TRAP_EN` defined: a DIV with operand 0 goes IDLE → WB directly. `alu_op_select` is not set to 5. `acc` and `flags` are unchanged, `err_div0`←1, and `done` pulses in cycle T0+1.
- Macro undefined: DIV by 0 executes normally and commits whatever the ALU returns. `err_div0` is tied 0.

## Structure
- Shared package `alu_seq_pkg` holds:
  - opcode constants
  - FSM state encoding (IDLE, EXEC, WB)
  - flag bit indices (C=3, V=2, N=1, Z=0)
  - the opcode-to-op_select mapping, kept identical to the ALU's selection order
- One sub-module, `alu_seq_wait_ctr`: loadable 4-bit down-counter with a zero flag, used for the EXEC settle.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
All scenarios use MULDIV_WAIT=2, with the real ALU connected as the ALU model.
1. Reset, LDA 0x7F, ADD 0x01 → `acc`=0x80, flags C0 V1 N1 Z0, `done` exactly 2 cycles after the ADD accept, `alu_sub`=0.
2. LDA 0x05, SUB 0x05 → `alu_sub`=1 during EXEC, `acc`=0x00, flags C1 V0 N0 Z1.
3. LDA 0x0C, MUL 0x0A → `acc`=0x78 at commit. `done` 4 cycles after accept, `instr_ready` low for cycles T0+1..T0+4.
4. With the macro defined: LDA 0x40, DIV 0x00 → `acc`=0x40, `err_div0`=1, `alu_op_select` never 5, `done` at T0+1. A following CLRF clears `err_div0` and flags.
5. Assert `rst` asynchronously during MUL EXEC → all outputs 0 before the next edge, no `done`. A subsequent LDA 0x11 is accepted and retires normally.
6. Hold `instr_valid` high with LDA 0xF0 then AND 0x3C queued → the AND is accepted only after WB returns to IDLE, `acc`=0x30, flags C0 V0 N0 Z0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU operation sequencer.
//   - opcode constants (instruction encoding)
//   - FSM state encoding (IDLE, EXEC, WB)
//   - flag bit indices inside the {C,V,N,Z} flag word
//   - opcode -> ALU op_select mapping, same selection order as the ALU
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_MUL  = 3'd4;
    localparam logic [2:0] OP_DIV  = 3'd5;
    localparam logic [2:0] OP_LDA  = 3'd6;
    localparam logic [2:0] OP_CLRF = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    // ALU select code for an opcode; non-ALU opcodes park the ALU on ADD.
    function automatic logic [2:0] op_select_of(input logic [2:0] opcode);
        logic [2:0] sel;
        case (opcode)
            OP_ADD:  sel = 3'd0;
            OP_SUB:  sel = 3'd1;
            OP_AND:  sel = 3'd2;
            OP_OR:   sel = 3'd3;
            OP_MUL:  sel = 3'd4;
            OP_DIV:  sel = 3'd5;
            default: sel = 3'd0;
        endcase
        return sel;
    endfunction

    function automatic logic is_muldiv(input logic [2:0] opcode);
        return (opcode == OP_MUL) || (opcode == OP_DIV);
    endfunction

    // Flag word for results whose carry/overflow are meaningless: C=V=0.
    function automatic logic [3:0] nz_flags(input logic [7:0] value);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = value[7];
        f[FLAG_Z] = (value == 8'h00);
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_wait_ctr.sv
// alu_seq_wait_ctr: loadable 4-bit down-counter with zero flag, times the
// EXEC settle period of the sequencer.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   load/load_val - load the count (has priority over dec)
//   dec           - decrement by one, saturating at zero
//   zero          - count is zero
module alu_seq_wait_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt_r;

    // Count register: load, saturating decrement, or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 4'd0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == 4'd0);

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one instruction at a time over valid/ready,
// drives the external combinational ALU from registers, waits the settle
// time and retires the result into the accumulator and {C,V,N,Z} flags.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   instr_valid/ready/opcode/operand - instruction handshake and payload
//   alu_a/alu_b/alu_sub/alu_op_select - registered ALU drive
//   alu_result, alu_cout, alu_overflow, alu_no, alu_zo - ALU outputs
//   acc, flags, err_div0        - architectural state
//   busy, done                  - status: not idle, one-cycle retire pulse
// Build option: ALU_SEQ_DIV0_TRAP_EN traps DIV by zero (no ALU access,
// acc/flags unchanged, sticky err_div0 set). Without it err_div0 is 0.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int MULDIV_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_opcode,
    input  logic [DATA_W-1:0] instr_operand,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_sub,
    output logic [2:0]        alu_op_select,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cout,
    input  logic              alu_overflow,
    input  logic              alu_no,
    input  logic              alu_zo,
    output logic [DATA_W-1:0] acc,
    output logic [3:0]        flags,
    output logic              err_div0,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] MULDIV_LOAD = 4'(MULDIV_WAIT);

    state_t      state_r;
    state_t      next_state_s;
    logic [2:0]  opcode_r;
    logic        accept_s;
    logic        trap_s;
    logic        direct_s;
    logic        ctr_zero_s;
    logic        commit_alu_s;
    logic        commit_direct_s;
    logic [3:0]  ctr_load_val_s;
    logic        done_r;
    logic        busy_r;

    assign instr_ready = (state_r == ST_IDLE);
    assign accept_s    = instr_valid && instr_ready;

`ifdef ALU_SEQ_DIV0_TRAP_EN
    assign trap_s = (instr_opcode == OP_DIV) && (instr_operand == {DATA_W{1'b0}});
`else
    assign trap_s = 1'b0;
`endif

    // Instructions that never touch the ALU commit at the accept edge.
    assign direct_s = (instr_opcode == OP_LDA) || (instr_opcode == OP_CLRF) || trap_s;

    alu_seq_wait_ctr u_wait_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .load_val (ctr_load_val_s),
        .dec      (state_r == ST_EXEC),
        .zero     (ctr_zero_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = direct_s ? ST_WB : ST_EXEC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (ctr_zero_s) begin
                    next_state_s = ST_WB;
                end else begin
                    next_state_s = ST_EXEC;
                end
            end
            ST_WB:   next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM output decode: commit strobes and settle-count load value.
    always_comb begin
        commit_alu_s    = 1'b0;
        commit_direct_s = 1'b0;
        ctr_load_val_s  = 4'd0;
        if (state_r == ST_EXEC) begin
            commit_alu_s = ctr_zero_s;
        end else begin
            commit_alu_s = 1'b0;
        end
        if (accept_s) begin
            commit_direct_s = direct_s;
            ctr_load_val_s  = is_muldiv(instr_opcode) ? MULDIV_LOAD : 4'd0;
        end else begin
            commit_direct_s = 1'b0;
            ctr_load_val_s  = 4'd0;
        end
    end

    // Status registers: busy covers EXEC and WB, done marks the WB cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_r <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            done_r <= (next_state_s == ST_WB);
            busy_r <= (next_state_s != ST_IDLE);
        end
    end

    // ALU drive latches (updated only at accept) and accumulator/flag commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode_r      <= 3'd0;
            alu_b         <= {DATA_W{1'b0}};
            alu_sub       <= 1'b0;
            alu_op_select <= 3'd0;
            acc           <= {DATA_W{1'b0}};
            flags         <= 4'b0000;
        end else begin
            if (accept_s) begin
                opcode_r      <= instr_opcode;
                alu_b         <= instr_operand;
                alu_sub       <= (instr_opcode == OP_SUB);
                alu_op_select <= trap_s ? 3'd0 : op_select_of(instr_opcode);
            end
            if (commit_alu_s) begin
                acc <= alu_result;
                if ((opcode_r == OP_ADD) || (opcode_r == OP_SUB)) begin
                    flags[FLAG_C] <= alu_cout;
                    flags[FLAG_V] <= alu_overflow;
                    flags[FLAG_N] <= alu_no;
                    flags[FLAG_Z] <= alu_zo;
                end else begin
                    flags <= nz_flags(alu_result);
                end
            end else if (commit_direct_s) begin
                case (instr_opcode)
                    OP_LDA: begin
                        acc           <= instr_operand;
                        flags[FLAG_N] <= instr_operand[DATA_W-1];
                        flags[FLAG_Z] <= (instr_operand == {DATA_W{1'b0}});
                    end
                    OP_CLRF: flags <= 4'b0000;
                    default: flags <= flags;   // trapped DIV leaves state alone
                endcase
            end
        end
    end

    assign alu_a = acc;
    assign busy  = busy_r;
    assign done  = done_r;

`ifdef ALU_SEQ_DIV0_TRAP_EN
    logic err_div0_r;

    // Sticky divide-by-zero error, cleared only by CLRF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_div0_r <= 1'b0;
        end else if (accept_s && (instr_opcode == OP_CLRF)) begin
            err_div0_r <= 1'b0;
        end else if (accept_s && trap_s) begin
            err_div0_r <= 1'b1;
        end else begin
            err_div0_r <= err_div0_r;
        end
    end

    assign err_div0 = err_div0_r;
`else
    assign err_div0 = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed self-checking bench for alu_op_sequencer
// with MULDIV_WAIT=2 and a behavioural 8-bit ALU connected to the drive lines.
module tb_alu_op_sequencer;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_opcode;
    logic [7:0] instr_operand;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_sub;
    logic [2:0] alu_op_select;
    logic [7:0] alu_result;
    logic       alu_cout;
    logic       alu_overflow;
    logic       alu_no;
    logic       alu_zo;
    logic [7:0] acc;
    logic [3:0] flags;
    logic       err_div0;
    logic       busy;
    logic       done;

    int tests_run    = 0;
    int tests_failed = 0;

    alu_op_sequencer #(.DATA_W(8), .MULDIV_WAIT(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_opcode  (instr_opcode),
        .instr_operand (instr_operand),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_sub       (alu_sub),
        .alu_op_select (alu_op_select),
        .alu_result    (alu_result),
        .alu_cout      (alu_cout),
        .alu_overflow  (alu_overflow),
        .alu_no        (alu_no),
        .alu_zo        (alu_zo),
        .acc           (acc),
        .flags         (flags),
        .err_div0      (err_div0),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: 0/1 add/sub (sub line selects subtract), 2 AND,
    // 3 OR, 4 MUL low byte, 5 DIV (divide by zero yields 0xFF).
    logic [8:0] sum9;
    always_comb begin
        sum9         = 9'd0;
        alu_result   = 8'h00;
        alu_cout     = 1'b0;
        alu_overflow = 1'b0;
        case (alu_op_select)
            3'd0, 3'd1: begin
                if (alu_sub) sum9 = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
                else         sum9 = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = sum9[7:0];
                alu_cout   = sum9[8];
                if (alu_sub) alu_overflow = (alu_a[7] != alu_b[7]) && (sum9[7] != alu_a[7]);
                else         alu_overflow = (alu_a[7] == alu_b[7]) && (sum9[7] != alu_a[7]);
            end
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = alu_a * alu_b;
            3'd5: alu_result = (alu_b == 8'h00) ? 8'hFF : alu_a / alu_b;
            default: alu_result = 8'h00;
        endcase
        alu_no = alu_result[7];
        alu_zo = (alu_result == 8'h00);
    end

    // Offer one instruction from a negedge; returns at the negedge of
    // cycle T0+1 with valid dropped.
    task automatic send(input logic [2:0] op, input logic [7:0] opr);
        int n;
        n = 0;
        while (instr_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (instr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL send_ready: instr_ready=%b required 1", instr_ready);
        end
        instr_valid   = 1'b1;
        instr_opcode  = op;
        instr_operand = opr;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr_opcode = 3'd0;
        instr_operand = 8'h00;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({acc, flags, alu_a, alu_b, alu_op_select, alu_sub, err_div0, done, busy} !== 38'd0) begin
            tests_failed++;
            $display("FAIL reset_values: acc=%h flags=%b b=%h sel=%0d sub=%b err=%b done=%b busy=%b required all 0",
                     acc, flags, alu_b, alu_op_select, alu_sub, err_div0, done, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({instr_ready, busy} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_ready: ready=%b busy=%b required 1 0", instr_ready, busy);
        end
    endtask

    task automatic test_add_overflow;
        send(3'd6, 8'h7F);
        tests_run++;
        if ({done, acc, busy} !== {1'b1, 8'h7F, 1'b1}) begin
            tests_failed++;
            $display("FAIL lda_7f: done=%b acc=%h busy=%b required 1 7f 1", done, acc, busy);
        end
        send(3'd0, 8'h01);
        tests_run++;
        if ({done, busy, instr_ready, alu_sub, alu_op_select, acc} !== {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h7F}) begin
            tests_failed++;
            $display("FAIL add_exec: done=%b busy=%b ready=%b sub=%b sel=%0d acc=%h required 0 1 0 0 0 7f",
                     done, busy, instr_ready, alu_sub, alu_op_select, acc);
        end
        @(negedge clk);
        tests_run++;
        if ({done, acc, flags} !== {1'b1, 8'h80, 4'b0110}) begin
            tests_failed++;
            $display("FAIL add_commit: done=%b acc=%h flags=%b required 1 80 0110", done, acc, flags);
        end
        @(negedge clk);
        tests_run++;
        if ({done, busy, instr_ready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL add_retire: done=%b busy=%b ready=%b required 0 0 1", done, busy, instr_ready);
        end
    endtask

    task automatic test_sub_zero;
        send(3'd6, 8'h05);
        send(3'd1, 8'h05);
        tests_run++;
        if ({alu_sub, alu_op_select, flags} !== {1'b1, 3'd1, 4'b0100}) begin
            tests_failed++;
            $display("FAIL sub_exec: sub=%b sel=%0d flags=%b required 1 1 0100", alu_sub, alu_op_select, flags);
        end
        @(negedge clk);
        tests_run++;
        if ({done, acc, flags} !== {1'b1, 8'h00, 4'b1001}) begin
            tests_failed++;
            $display("FAIL sub_commit: done=%b acc=%h flags=%b required 1 00 1001", done, acc, flags);
        end
    endtask

    task automatic test_mul_wait;
        logic [3:0] ready_seen;
        logic [3:0] done_seen;
        send(3'd6, 8'h0C);
        send(3'd4, 8'h0A);
        for (int k = 0; k < 4; k++) begin
            ready_seen[k] = instr_ready;
            done_seen[k]  = done;
            if (k == 2) begin
                tests_run++;
                if ({acc, flags} !== {8'h0C, 4'b1000}) begin
                    tests_failed++;
                    $display("FAIL mul_hold: acc=%h flags=%b required 0c 1000 before commit", acc, flags);
                end
            end
            if (k < 3) @(negedge clk);
        end
        tests_run++;
        if ({ready_seen, done_seen} !== {4'b0000, 4'b1000}) begin
            tests_failed++;
            $display("FAIL mul_timing: ready T1..T4=%b done T1..T4(msb=T4)=%b required 0000 1000",
                     ready_seen, done_seen);
        end
        tests_run++;
        if ({acc, flags} !== {8'h78, 4'b0000}) begin
            tests_failed++;
            $display("FAIL mul_commit: acc=%h flags=%b required 78 0000", acc, flags);
        end
        @(negedge clk);
        tests_run++;
        if (instr_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mul_ready: ready=%b required 1", instr_ready);
        end
    endtask

    task automatic test_div_zero;
        send(3'd6, 8'h40);
`ifdef ALU_SEQ_DIV0_TRAP_EN
        send(3'd5, 8'h00);
        tests_run++;
        if ({done, acc, flags, err_div0} !== {1'b1, 8'h40, 4'b0000, 1'b1} || alu_op_select === 3'd5) begin
            tests_failed++;
            $display("FAIL div0_trap: done=%b acc=%h flags=%b err=%b sel=%0d required 1 40 0000 1 sel!=5",
                     done, acc, flags, err_div0, alu_op_select);
        end
        send(3'd6, 8'h80);
        tests_run++;
        if ({acc, flags, err_div0} !== {8'h80, 4'b0010, 1'b1}) begin
            tests_failed++;
            $display("FAIL div0_sticky: acc=%h flags=%b err=%b required 80 0010 1", acc, flags, err_div0);
        end
        send(3'd7, 8'h00);
        tests_run++;
        if ({done, acc, flags, err_div0} !== {1'b1, 8'h80, 4'b0000, 1'b0}) begin
            tests_failed++;
            $display("FAIL clrf: done=%b acc=%h flags=%b err=%b required 1 80 0000 0", done, acc, flags, err_div0);
        end
`else
        send(3'd5, 8'h00);
        tests_run++;
        if ({done, alu_op_select, err_div0} !== {1'b0, 3'd5, 1'b0}) begin
            tests_failed++;
            $display("FAIL div0_exec: done=%b sel=%0d err=%b required 0 5 0", done, alu_op_select, err_div0);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if ({done, acc, flags, err_div0} !== {1'b1, 8'hFF, 4'b0010, 1'b0}) begin
            tests_failed++;
            $display("FAIL div0_commit: done=%b acc=%h flags=%b err=%b required 1 ff 0010 0", done, acc, flags, err_div0);
        end
        send(3'd7, 8'h00);
        tests_run++;
        if ({done, acc, flags, err_div0} !== {1'b1, 8'hFF, 4'b0000, 1'b0}) begin
            tests_failed++;
            $display("FAIL clrf: done=%b acc=%h flags=%b err=%b required 1 ff 0000 0", done, acc, flags, err_div0);
        end
`endif
    endtask

    task automatic test_async_reset;
        int done_hits;
        send(3'd6, 8'h03);
        send(3'd4, 8'h03);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mul_busy: busy=%b required 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({acc, flags, alu_a, alu_b, alu_op_select, alu_sub, err_div0, done, busy} !== 38'd0) begin
            tests_failed++;
            $display("FAIL async_reset: acc=%h flags=%b a=%h b=%h sel=%0d sub=%b err=%b done=%b busy=%b required all 0",
                     acc, flags, alu_a, alu_b, alu_op_select, alu_sub, err_div0, done, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        done_hits = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done === 1'b1) done_hits++;
        end
        tests_run++;
        if (done_hits != 0) begin
            tests_failed++;
            $display("FAIL no_done_after_reset: done pulses=%0d required 0", done_hits);
        end
        send(3'd6, 8'h11);
        tests_run++;
        if ({done, acc, flags} !== {1'b1, 8'h11, 4'b0000}) begin
            tests_failed++;
            $display("FAIL lda_after_reset: done=%b acc=%h flags=%b required 1 11 0000", done, acc, flags);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        n = 0;
        while (instr_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        instr_valid   = 1'b1;
        instr_opcode  = 3'd6;
        instr_operand = 8'hF0;
        @(posedge clk);
        @(negedge clk);
        // WB of the LDA: queue the AND while still busy
        instr_opcode  = 3'd2;
        instr_operand = 8'h3C;
        tests_run++;
        if ({done, instr_ready, acc, flags} !== {1'b1, 1'b0, 8'hF0, 4'b0010}) begin
            tests_failed++;
            $display("FAIL b2b_lda: done=%b ready=%b acc=%h flags=%b required 1 0 f0 0010", done, instr_ready, acc, flags);
        end
        @(negedge clk);
        tests_run++;
        if ({instr_ready, busy, alu_b, alu_op_select} !== {1'b1, 1'b0, 8'hF0, 3'd0}) begin
            tests_failed++;
            $display("FAIL b2b_not_early: ready=%b busy=%b b=%h sel=%0d required 1 0 f0 0",
                     instr_ready, busy, alu_b, alu_op_select);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        tests_run++;
        if ({busy, alu_b, alu_op_select} !== {1'b1, 8'h3C, 3'd2}) begin
            tests_failed++;
            $display("FAIL b2b_accept: busy=%b b=%h sel=%0d required 1 3c 2", busy, alu_b, alu_op_select);
        end
        @(negedge clk);
        tests_run++;
        if ({done, acc, flags} !== {1'b1, 8'h30, 4'b0000}) begin
            tests_failed++;
            $display("FAIL b2b_and: done=%b acc=%h flags=%b required 1 30 0000", done, acc, flags);
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_zero();
        test_mul_wait();
        test_div_zero();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
